stream_capture: RTL and testbench
=================================

STREAM_CAPTURE -- requirements
Module: stream_capture

Interface
REQ-001 Parameter W, default 256, image width in pixels.
REQ-002 Parameter H, default 256, image height in rows.
REQ-003 Parameter ADDR_W, default 16, frame-RAM address width, SHALL satisfy 2**ADDR_W >= W*H.
REQ-004 Clk_in  input  1  single clock; all logic on rising edge.
REQ-005 Rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 Start_in  input  1  one-cycle pulse marking the first pixel of a frame, coincident with H_Valid_in.
REQ-007 H_Valid_in  input  1  Bmp_Data carries a valid pixel this cycle.
REQ-008 H_Jump_in  input  1  one-cycle end-of-row pulse, H_Valid_in low.
REQ-009 Bmp_Data  input  24  RGB pixel, RRGGBB.
REQ-010 Wr_En_out  output  1  frame-RAM write strobe.
REQ-011 Wr_Addr_out  output  ADDR_W  write address, row*W+col.
REQ-012 Wr_Data_out  output  24  write data.
REQ-013 Frame_Done_out  output  1  one-cycle pulse after the last row's H_Jump_in.
REQ-014 Busy_out  output  1  high while a frame is being captured.
REQ-015 Err_out  output  1  sticky protocol-error flag.

Function
REQ-016 All outputs SHALL be registered; a pixel sampled at edge N SHALL appear on Wr_En_out/Wr_Addr_out/Wr_Data_out after edge N (latency 1).
REQ-017 FSM states: IDLE, CAPTURE, WAIT_JUMP, DONE.
REQ-018 IDLE: Start_in&H_Valid_in -> write Bmp_Data at address 0, col=1, row=0, clear Err_out, go CAPTURE; H_Valid_in or H_Jump_in without Start_in ignored, no write.
REQ-019 CAPTURE: H_Valid_in -> write at current address, address+1, col+1; after the W-th pixel of a row go WAIT_JUMP.
REQ-020 WAIT_JUMP: H_Jump_in -> col=0, row+1; if row was H-1 go DONE, else CAPTURE.
REQ-021 DONE: assert Frame_Done_out for exactly one cycle, return to IDLE.
REQ-022 Address SHALL be an incrementing counter (no multiplier); short rows SHALL realign address to (row+1)*W.
REQ-023 H_Jump_in in CAPTURE with col<W (short row): set Err_out, advance row as in REQ-020.
REQ-024 H_Valid_in in WAIT_JUMP (long row): set Err_out, drop pixel, no write, stay WAIT_JUMP.
REQ-025 H_Valid_in and H_Jump_in together: set Err_out, treat as H_Jump_in only, pixel dropped.
REQ-026 Start_in outside IDLE: set Err_out, restart frame — write pixel at address 0, col=1, row=0, state CAPTURE; Err_out stays set.
REQ-027 Busy_out high in CAPTURE and WAIT_JUMP, low in IDLE and DONE.
REQ-028 Wr_Data_out SHALL hold its last value when Wr_En_out is low.

Reset
REQ-029 Rst_n_in low SHALL immediately force IDLE, counters 0, and all outputs 0, independent of Clk_in.
REQ-030 Reset mid-frame SHALL abandon the frame with no Frame_Done_out; the next frame requires a new Start_in.

Structure
REQ-031 Shared package: FSM state enum, default W/H/ADDR_W constants, pixel-width constant (24).
REQ-032 One sub-module, stream_pos_counter: col/row/address counters with increment, row-advance and clear controls; FSM stays in stream_capture.

Verification (run with W=4, H=4)
REQ-033 Full frame, pixel k=0x000000+k, protocol as specified -> 16 writes, addresses 0..15, data 0..15, one Frame_Done_out after the 4th H_Jump_in, Err_out=0.
REQ-034 Row 1 sends 3 pixels then H_Jump_in -> Err_out=1, row 2 first write at address 8, Frame_Done_out still pulses.
REQ-035 Row 0 sends 5 pixels -> 5th dropped, no write at address 4 from row 0, Err_out=1.
REQ-036 Start_in at row 2, col 1 -> Err_out=1, next write at address 0, full 16-pixel frame then completes.
REQ-037 Rst_n_in low during row 2 -> outputs 0 asynchronously, no Frame_Done_out; H_Valid_in without Start_in afterwards -> no writes.
REQ-038 H_Valid_in and H_Jump_in together at row 0 end -> no write, Err_out=1, row 1 starts at address 4.

Source files
------------

// File: rtl/stream_capture_pkg.sv
// Shared types and constants for the stream capture block.
// Holds the capture FSM encoding, default geometry and pixel width.
package stream_capture_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        WAIT_JUMP = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int DEF_W      = 256;
    localparam int DEF_H      = 256;
    localparam int DEF_ADDR_W = 16;
    localparam int PIX_W      = 24;

    // Counter width able to hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stream_pos_counter.sv
// Column / row / frame-address counters for the capture path.
// The address is kept incrementally; a row advance realigns it to the next row base.
module stream_pos_counter
    import stream_capture_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int H      = DEF_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COL_W  = cnt_width(W),
    parameter int ROW_W  = cnt_width(H)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_first,
    input  logic              i_inc,
    input  logic              i_row_adv,
    output logic [COL_W-1:0]  o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(W);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_row_base;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= '0;
            r_row_base <= '0;
        end else if (i_first) begin
            // Pixel 0 is written this cycle, so the next free slot is address 1.
            r_col      <= COL_W'(1);
            r_row      <= '0;
            r_addr     <= ADDR_W'(1);
            r_row_base <= '0;
        end else if (i_row_adv) begin
            r_col      <= '0;
            r_row      <= r_row + ROW_W'(1);
            r_row_base <= r_row_base + ROW_STEP;
            r_addr     <= r_row_base + ROW_STEP;
        end else if (i_inc) begin
            r_col  <= r_col + COL_W'(1);
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_addr = r_addr;

endmodule

// File: rtl/stream_capture.sv
// Captures a raster pixel stream into frame RAM write strobes.
// Detects short/long rows, stray Start pulses and valid+jump collisions via a sticky error.
module stream_capture
    import stream_capture_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int H      = DEF_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk_in,
    input  logic              Rst_n_in,
    input  logic              Start_in,
    input  logic              H_Valid_in,
    input  logic              H_Jump_in,
    input  logic [PIX_W-1:0]  Bmp_Data,
    output logic              Wr_En_out,
    output logic [ADDR_W-1:0] Wr_Addr_out,
    output logic [PIX_W-1:0]  Wr_Data_out,
    output logic              Frame_Done_out,
    output logic              Busy_out,
    output logic              Err_out
);

    localparam int COL_W = cnt_width(W);
    localparam int ROW_W = cnt_width(H);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(H - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_wr_en, r_frame_done, r_busy, r_err;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;

    logic              w_first, w_inc, w_row_adv;
    logic              w_wr_en, w_err;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [PIX_W-1:0]  w_wr_data;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_addr;

    stream_pos_counter #(
        .W      (W),
        .H      (H),
        .ADDR_W (ADDR_W),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_pos (
        .i_clk     (Clk_in),
        .i_rst_n   (Rst_n_in),
        .i_first   (w_first),
        .i_inc     (w_inc),
        .i_row_adv (w_row_adv),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_addr    (w_addr)
    );

    always_comb begin
        w_state_next = r_state;
        w_first      = 1'b0;
        w_inc        = 1'b0;
        w_row_adv    = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_wr_data    = r_wr_data;
        w_err        = r_err;

        if (Start_in && H_Valid_in) begin
            // A start in any state other than IDLE is a restart and leaves the error latched.
            w_first      = 1'b1;
            w_wr_en      = 1'b1;
            w_wr_addr    = '0;
            w_wr_data    = Bmp_Data;
            w_err        = (r_state == IDLE) ? 1'b0 : 1'b1;
            w_state_next = CAPTURE;
        end else begin
            unique case (r_state)
                IDLE: ;
                CAPTURE: begin
                    if (H_Jump_in) begin
                        // Still in CAPTURE means fewer than W pixels arrived: short row.
                        w_err        = 1'b1;
                        w_row_adv    = 1'b1;
                        w_state_next = (w_row == LAST_ROW) ? DONE : CAPTURE;
                    end else if (H_Valid_in) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = w_addr;
                        w_wr_data = Bmp_Data;
                        w_inc     = 1'b1;
                        if (w_col == LAST_COL) begin
                            w_state_next = WAIT_JUMP;
                        end
                    end
                end
                WAIT_JUMP: begin
                    if (H_Jump_in) begin
                        if (H_Valid_in) begin
                            w_err = 1'b1;
                        end
                        w_row_adv    = 1'b1;
                        w_state_next = (w_row == LAST_ROW) ? DONE : CAPTURE;
                    end else if (H_Valid_in) begin
                        w_err = 1'b1;
                    end
                end
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_state      <= IDLE;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wr_en      <= w_wr_en;
            r_wr_addr    <= w_wr_addr;
            r_wr_data    <= w_wr_data;
            r_frame_done <= (w_state_next == DONE);
            r_busy       <= (w_state_next == CAPTURE) || (w_state_next == WAIT_JUMP);
            r_err        <= w_err;
        end
    end

    assign Wr_En_out      = r_wr_en;
    assign Wr_Addr_out    = r_wr_addr;
    assign Wr_Data_out    = r_wr_data;
    assign Frame_Done_out = r_frame_done;
    assign Busy_out       = r_busy;
    assign Err_out        = r_err;

endmodule

// File: tb/tb_stream_capture.sv
// Scoreboard bench for stream_capture on a 4x4 frame.
// Stimulus pushes expected writes; a negedge monitor pops and compares each write.
module tb_stream_capture;

    localparam int TW = 4;
    localparam int TH = 4;
    localparam int TA = 4;

    logic          Clk_in = 1'b0;
    logic          Rst_n_in = 1'b0;
    logic          Start_in = 1'b0;
    logic          H_Valid_in = 1'b0;
    logic          H_Jump_in = 1'b0;
    logic [23:0]   Bmp_Data = '0;
    logic          Wr_En_out;
    logic [TA-1:0] Wr_Addr_out;
    logic [23:0]   Wr_Data_out;
    logic          Frame_Done_out;
    logic          Busy_out;
    logic          Err_out;

    typedef struct {
        logic [15:0] addr;
        logic [23:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [23:0] last_data = '0;

    stream_capture #(.W(TW), .H(TH), .ADDR_W(TA)) dut (
        .Clk_in         (Clk_in),
        .Rst_n_in       (Rst_n_in),
        .Start_in       (Start_in),
        .H_Valid_in     (H_Valid_in),
        .H_Jump_in      (H_Jump_in),
        .Bmp_Data       (Bmp_Data),
        .Wr_En_out      (Wr_En_out),
        .Wr_Addr_out    (Wr_Addr_out),
        .Wr_Data_out    (Wr_Data_out),
        .Frame_Done_out (Frame_Done_out),
        .Busy_out       (Busy_out),
        .Err_out        (Err_out)
    );

    initial forever #5 Clk_in = ~Clk_in;

    // Monitor: every write must match the oldest expectation; idle cycles must hold data.
    always @(negedge Clk_in) begin
        if (Wr_En_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%06h, required no write", Wr_Addr_out, Wr_Data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ((16'(Wr_Addr_out) !== e.addr) || (Wr_Data_out !== e.data)) begin
                    errors++;
                    $display("FAIL write: addr=%0h data=%06h, required addr=%0h data=%06h",
                             Wr_Addr_out, Wr_Data_out, e.addr, e.data);
                end
                last_data = e.data;
            end
        end else begin
            checks++;
            if (Wr_Data_out !== last_data) begin
                errors++;
                $display("FAIL data_hold: Wr_Data_out=%06h, required %06h", Wr_Data_out, last_data);
            end
        end
        if (Frame_Done_out === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic drive(input bit s, input bit v, input bit j, input logic [23:0] d);
        @(negedge Clk_in);
        Start_in = s; H_Valid_in = v; H_Jump_in = j; Bmp_Data = d;
        @(posedge Clk_in);
        #1;
        Start_in = 1'b0; H_Valid_in = 1'b0; H_Jump_in = 1'b0; Bmp_Data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk_in);
    endtask

    task automatic send_row(input int n, input int a0, input int d0, input bit start_first, input int n_wr);
        for (int i = 0; i < n; i++) begin
            if (i < n_wr) exp_q.push_back('{addr: 16'(a0 + i), data: 24'(d0 + i)});
            drive(start_first && (i == 0), 1'b1, 1'b0, 24'(d0 + i));
        end
    endtask

    task automatic jump();
        drive(1'b0, 1'b0, 1'b1, 24'h0);
    endtask

    task automatic frame_rows(input int r_from, input int dbase);
        for (int r = r_from; r < TH; r++) begin
            send_row(TW, r * TW, dbase + r * TW, (r == 0), TW);
            idle(1);
            jump();
        end
    endtask

    task automatic end_frame(input string name, input int done_before, input int exp_done, input bit exp_err);
        idle(3);
        chk({name, "_done_pulses"}, done_cnt - done_before, exp_done);
        chk({name, "_err"}, Err_out, exp_err);
        chk({name, "_busy_after"}, Busy_out, 1'b0);
        chk({name, "_pending_writes"}, exp_q.size(), 0);
    endtask

    int d0;

    initial begin
        // Reset state
        idle(2);
        chk("rst_wr_en", Wr_En_out, 0);
        chk("rst_wr_addr", Wr_Addr_out, 0);
        chk("rst_wr_data", Wr_Data_out, 0);
        chk("rst_done", Frame_Done_out, 0);
        chk("rst_busy", Busy_out, 0);
        chk("rst_err", Err_out, 0);
        Rst_n_in = 1'b1;
        idle(2);

        // Clean frame, data == address
        d0 = done_cnt;
        send_row(1, 0, 0, 1'b1, 1);
        chk("t1_busy_mid", Busy_out, 1'b1);
        send_row(3, 1, 1, 1'b0, 3);
        idle(1);
        jump();
        frame_rows(1, 0);
        end_frame("t1", d0, 1, 1'b0);

        // Short row 1 realigns row 2 to address 8
        d0 = done_cnt;
        send_row(4, 0, 'h100, 1'b1, 4); idle(1); jump();
        send_row(3, 4, 'h104, 1'b0, 3); idle(1); jump();
        chk("t2_err_short", Err_out, 1'b1);
        frame_rows(2, 'h100);
        end_frame("t2", d0, 1, 1'b1);

        // Long row 0: fifth pixel dropped
        d0 = done_cnt;
        send_row(1, 0, 'h300, 1'b1, 1);
        chk("t3_err_cleared", Err_out, 1'b0);
        send_row(4, 1, 'h301, 1'b0, 3);
        chk("t3_err_long", Err_out, 1'b1);
        idle(1); jump();
        frame_rows(1, 'h300);
        end_frame("t3", d0, 1, 1'b1);

        // Start at row 2 col 1 restarts the frame
        d0 = done_cnt;
        send_row(4, 0, 'h400, 1'b1, 4); idle(1); jump();
        send_row(4, 4, 'h404, 1'b0, 4); idle(1); jump();
        send_row(1, 8, 'h408, 1'b0, 1);
        chk("t4_err_before", Err_out, 1'b0);
        frame_rows(0, 'h500);
        end_frame("t4", d0, 1, 1'b1);

        // Asynchronous reset during row 2
        d0 = done_cnt;
        send_row(4, 0, 'h700, 1'b1, 4); idle(1); jump();
        send_row(4, 4, 'h704, 1'b0, 4); idle(1); jump();
        send_row(2, 8, 'h708, 1'b0, 2);
        @(negedge Clk_in);
        #2 Rst_n_in = 1'b0;
        #1;
        chk("t5_wr_en", Wr_En_out, 0);
        chk("t5_wr_addr", Wr_Addr_out, 0);
        chk("t5_wr_data", Wr_Data_out, 0);
        chk("t5_busy", Busy_out, 0);
        chk("t5_done", Frame_Done_out, 0);
        last_data = '0;
        #1 Rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 24'h0000AA + 24'(i));
        jump();
        end_frame("t5", d0, 0, 1'b0);

        // Valid and jump together at the end of row 0
        d0 = done_cnt;
        send_row(4, 0, 'h600, 1'b1, 4);
        drive(1'b0, 1'b1, 1'b1, 24'hABCDEF);
        chk("t6_err_collide", Err_out, 1'b1);
        chk("t6_busy", Busy_out, 1'b1);
        frame_rows(1, 'h600);
        end_frame("t6", d0, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
